ds18b20_temp_to_digits: RTL and testbench

- Converts the raw 16-bit DS18B20 temperature word into four decimal digit indices, Num1..Num4, for the 4-digit 74HC595 seven-segment driver.
- The driver shows the word as "Num1 Num2 Num3 . Num4": the decimal point sits on digit 3, and Num4 carries tenths of a degree.
- Sits between the DS18B20 1-Wire reader (upstream) and the display driver (downstream).
- Uses a sequential scale stage followed by an iterative shift-add-3 (double-dabble) BCD conversion, and updates all four digits atomically.

---
 rtl/ds18b20_temp_to_digits.sv | 154 +++++++++++++++
 tb/tb_ds18b20_temp_to_digits.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/ds18b20_temp_to_digits.sv
// DS18B20 raw word to four display digit indices (hundreds..tenths of degC).
// Optional macro TEMP_SIGN_EN: show a minus sign (index 11) for negatives.
module ds18b20_temp_to_digits #(
  parameter int ITER = 14
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [15:0] temp_raw,
  input  logic        temp_valid,
  output logic [7:0]  Num1,
  output logic [7:0]  Num2,
  output logic [7:0]  Num3,
  output logic [7:0]  Num4,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    COMMIT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] raw_q, raw_d;
  logic [29:0] sr_q, sr_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  n1_q, n1_d;
  logic [7:0]  n2_q, n2_d;
  logic [7:0]  n3_q, n3_d;
  logic [7:0]  n4_q, n4_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [16:0] mag;
  logic [19:0] prod;
  logic [15:0] tenths;
  logic [13:0] clamp;
  logic [29:0] adj;

  // Scale 1/16 degC magnitude to rounded, clamped tenths of a degree
  always_comb begin
    mag    = raw_q[15] ? (17'h10000 - {1'b0, raw_q})
                       : {1'b0, raw_q};
    prod   = {3'b0, mag} * 20'd10 + 20'd8;
    tenths = 16'(prod >> 4);
    clamp  = (tenths > 16'd9999) ? 14'd9999 : tenths[13:0];
`ifdef TEMP_SIGN_EN
    if (raw_q[15] && (clamp > 14'd999)) begin
      clamp = 14'd999;
    end
`else
    if (raw_q[15]) begin
      clamp = '0;
    end
`endif
  end

  // Double-dabble correction: add 3 to each BCD nibble that is >= 5
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++) begin
      if (sr_q[14+4*i +: 4] >= 4'd5) begin
        adj[14+4*i +: 4] = sr_q[14+4*i +: 4] + 4'd3;
      end
    end
  end

  // Sequencer: latch, scale, shift ITER times, then commit all digits
  always_comb begin
    state_d = state_q;
    raw_d   = raw_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    n1_d    = n1_q;
    n2_d    = n2_q;
    n3_d    = n3_q;
    n4_d    = n4_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (temp_valid) begin
          raw_d   = temp_raw;
          busy_d  = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        sr_d    = {16'b0, clamp};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        sr_d  = {adj[28:0], 1'b0};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(ITER - 1)) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        n1_d = {4'b0, sr_q[29:26]};
`ifdef TEMP_SIGN_EN
        if (raw_q[15]) begin
          n1_d = 8'd11;
        end
`endif
        n2_d    = {4'b0, sr_q[25:22]};
        n3_d    = {4'b0, sr_q[21:18]};
        n4_d    = {4'b0, sr_q[17:14]};
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      raw_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      n1_q    <= '0;
      n2_q    <= '0;
      n3_q    <= '0;
      n4_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      raw_q   <= raw_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      n1_q    <= n1_d;
      n2_q    <= n2_d;
      n3_q    <= n3_d;
      n4_q    <= n4_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Num1 = n1_q;
  assign Num2 = n2_q;
  assign Num3 = n3_q;
  assign Num4 = n4_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ds18b20_temp_to_digits.sv
// Bench for ds18b20_temp_to_digits: directed cases plus random words
// checked against an arithmetic reference of the temperature display.
module tb_ds18b20_temp_to_digits;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [15:0] temp_raw = '0;
  logic        temp_valid = 1'b0;
  logic [7:0]  Num1, Num2, Num3, Num4;
  logic        busy, done;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] shown = '0;

  ds18b20_temp_to_digits dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .temp_raw   (temp_raw),
    .temp_valid (temp_valid),
    .Num1       (Num1),
    .Num2       (Num2),
    .Num3       (Num3),
    .Num4       (Num4),
    .busy       (busy),
    .done       (done)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] model(input logic [15:0] raw);
    int v, mag, t, d1;
    bit neg;
    v   = int'($signed(raw));
    neg = (v < 0);
    mag = neg ? -v : v;
    t   = (mag * 10 + 8) / 16;
    if (t > 9999) t = 9999;
`ifdef TEMP_SIGN_EN
    if (neg && t > 999) t = 999;
    d1 = neg ? 11 : t / 1000;
`else
    if (neg) t = 0;
    d1 = t / 1000;
`endif
    return {8'(d1), 8'((t / 100) % 10),
            8'((t / 10) % 10), 8'(t % 10)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] digits();
    return {Num1, Num2, Num3, Num4};
  endfunction

  // Strobe raw now; optionally re-strobe extra_raw before edge extra_at
  task automatic run_conv(input logic [15:0] raw, input int extra_at,
                          input logic [15:0] extra_raw,
                          input string tag);
    logic [31:0] exp;
    exp = model(raw);
    temp_raw   = raw;
    temp_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    temp_valid = 1'b0;
    temp_raw   = 16'($urandom);
    check({tag, " busy@E0"}, {31'b0, busy}, 32'd1);
    check({tag, " done@E0"}, {31'b0, done}, 32'd0);
    for (int n = 1; n <= 16; n++) begin
      if (n == extra_at) begin
        temp_valid = 1'b1;
        temp_raw   = extra_raw;
      end
      @(posedge sys_clk);
      #1;
      temp_valid = 1'b0;
      if (n < 16) begin
        if (n == 8) begin
          check({tag, " hold"}, digits(), shown);
        end
        check({tag, " early done"}, {31'b0, done}, 32'd0);
        check({tag, " busy mid"}, {31'b0, busy}, 32'd1);
      end else begin
        check({tag, " digits"}, digits(), exp);
        check({tag, " done@E16"}, {31'b0, done}, 32'd1);
        check({tag, " busy@E16"}, {31'b0, busy}, 32'd0);
      end
    end
    shown = exp;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge sys_clk);
      #1;
      check("idle done", {31'b0, done}, 32'd0);
      check("idle digits", digits(), shown);
    end
  endtask

  initial begin
    logic [15:0] r;
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    check("reset digits", digits(), 32'd0);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    idle(2);

    run_conv(16'h0191, 0, 16'h0, "25.0625");
    check("25.0625 literal", digits(), 32'h00020501);
    idle(1);
    run_conv(16'h07D0, 0, 16'h0, "125");
    check("125 literal", digits(), 32'h01020500);
    idle(2);
    run_conv(16'h0550, 0, 16'h0, "85");
    check("85 literal", digits(), 32'h00080500);
    idle(1);
    run_conv(16'h0000, 0, 16'h0, "zero");
    idle(1);
    run_conv(16'h7FFF, 5, 16'h0550, "clamp+ignored");
    check("clamp literal", digits(), 32'h09090909);
    idle(20);
    run_conv(16'h8000, 0, 16'h0, "most negative");
    idle(1);
    run_conv(16'hFC90, 0, 16'h0, "-55");
    idle(1);
    run_conv(16'hFF5E, 0, 16'h0, "-10.125");
`ifdef TEMP_SIGN_EN
    check("-10.125 literal", digits(), 32'h0B010001);
`else
    check("-10.125 literal", digits(), 32'h0);
`endif
    idle(1);

    run_conv(16'h0191, 0, 16'h0, "b2b first");
    run_conv(16'h0550, 0, 16'h0, "b2b second");
    idle(2);

    for (int k = 0; k < 24; k++) begin
      if (k % 3 == 0) r = 16'($urandom);
      else if (k % 3 == 1) r = 16'($urandom_range(0, 16'h07D0));
      else r = 16'(-int'($urandom_range(1, 16'h0370)));
      run_conv(r, 0, 16'h0, "random");
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    run_conv(16'h07D0, 0, 16'h0, "pre-abort");
    temp_raw   = 16'h0550;
    temp_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    temp_valid = 1'b0;
    repeat (8) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    #1;
    check("abort digits", digits(), 32'd0);
    check("abort busy", {31'b0, busy}, 32'd0);
    check("abort done", {31'b0, done}, 32'd0);
    repeat (2) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    shown = '0;
    idle(20);
    check("post-abort busy", {31'b0, busy}, 32'd0);
    run_conv(16'h0191, 0, 16'h0, "after abort");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
